// File: rtl/mc_controller_pkg.sv
// Shared state, opcode, funct and ALU-code definitions for the multicycle controller.
// Defining MC_JAL_EN enables the jal instruction (JAL state).
package mc_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12
    } state_t;

    // Selects which decode mc_aludec applies in the current state.
    typedef enum logic [2:0] {
        AOP_NONE,
        AOP_ADD,
        AOP_SUB,
        AOP_FUNCT,
        AOP_IMM
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;

    // alu32 F codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SRA = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;
    localparam logic [3:0] ALU_SUB = 4'b1010;
    localparam logic [3:0] ALU_SLT = 4'b1011;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // DECODE successor; S_FETCH here means the opcode is unsupported.
    function automatic state_t decode_next(input logic [5:0] op);
        state_t nxt;
        case (op)
            OP_LW, OP_SW:   nxt = S_MEMADR;
            OP_RTYPE:       nxt = S_EXEC;
            OP_BEQ, OP_BNE: nxt = S_BRANCH;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: nxt = S_IMMEX;
            OP_J:           nxt = S_JUMP;
`ifdef MC_JAL_EN
            OP_JAL:         nxt = S_JAL;
`endif
            default:        nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Instruction-field inputs and datapath control outputs of the multicycle controller.
// The jal bit forces the register write address to r31 when MC_JAL_EN is built in.
interface mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [3:0] alucontrol;
    logic       illegal;
    logic [3:0] state;
    logic       jal;

    modport master (
        output op, funct, zero,
        input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, illegal, state, jal
    );

    modport slave (
        input  op, funct, zero,
        output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, illegal, state, jal
    );
endinterface

// File: rtl/mc_aludec.sv
// Combinational op/funct to alu32 F-code decode for the multicycle controller.
module mc_aludec
    import mc_controller_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [3:0] alucontrol,
    output logic       funct_ok
);

    always_comb begin
        alucontrol = ALU_AND;
        funct_ok   = 1'b0;
        case (aluop)
            AOP_ADD: alucontrol = ALU_ADD;
            AOP_SUB: alucontrol = ALU_SUB;
            AOP_FUNCT: begin
                funct_ok = 1'b1;
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    FN_SLL:  alucontrol = ALU_SLL;
                    FN_SRL:  alucontrol = ALU_SRL;
                    FN_SRA:  alucontrol = ALU_SRA;
                    default: funct_ok = 1'b0;
                endcase
            end
            AOP_IMM: begin
                case (op)
                    OP_ADDI: alucontrol = ALU_ADD;
                    OP_ANDI: alucontrol = ALU_AND;
                    OP_ORI:  alucontrol = ALU_OR;
                    OP_XORI: alucontrol = ALU_XOR;
                    OP_SLTI: alucontrol = ALU_SLT;
                    default: alucontrol = ALU_AND;
                endcase
            end
            default: alucontrol = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Moore FSM controller for a multicycle MIPS datapath.
// Defining MC_JAL_EN adds the JAL state; otherwise op 000011 is illegal.
module mc_controller
    import mc_controller_pkg::*;
(
    input logic       clk,
    input logic       reset,
    mc_controller_if.slave bus
);

    state_t     state_q, state_d;
    aluop_t     aluop;
    logic [3:0] alucontrol;
    logic       funct_ok;
    logic       pcwrite, branch;
    logic       iord_c, memwrite_c, irwrite_c, regdst_c, memtoreg_c;
    logic       regwrite_c, alusrca_c, illegal_c, jal_c;
    logic [1:0] alusrcb_c, pcsrc_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    mc_aludec u_aludec (
        .aluop      (aluop),
        .op         (bus.op),
        .funct      (bus.funct),
        .alucontrol (alucontrol),
        .funct_ok   (funct_ok)
    );

    always_comb begin
        state_d    = S_FETCH;
        aluop      = AOP_NONE;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        iord_c     = 1'b0;
        memwrite_c = 1'b0;
        irwrite_c  = 1'b0;
        regdst_c   = 1'b0;
        memtoreg_c = 1'b0;
        regwrite_c = 1'b0;
        alusrca_c  = 1'b0;
        illegal_c  = 1'b0;
        jal_c      = 1'b0;
        alusrcb_c  = SRCB_REG;
        pcsrc_c    = PC_ALU;
        case (state_q)
            S_FETCH: begin
                irwrite_c = 1'b1;
                alusrcb_c = SRCB_FOUR;
                aluop     = AOP_ADD;
                pcwrite   = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                alusrcb_c = SRCB_IMMSH;
                aluop     = AOP_ADD;
                state_d   = decode_next(bus.op);
                illegal_c = (state_d == S_FETCH);
            end
            S_MEMADR: begin
                alusrca_c = 1'b1;
                alusrcb_c = SRCB_IMM;
                aluop     = AOP_ADD;
                state_d   = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord_c  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite_c = 1'b1;
                memtoreg_c = 1'b1;
            end
            S_MEMWR: begin
                iord_c     = 1'b1;
                memwrite_c = 1'b1;
            end
            S_EXEC: begin
                alusrca_c = 1'b1;
                aluop     = AOP_FUNCT;
                if (funct_ok) state_d = S_ALUWB;
                else          illegal_c = 1'b1;
            end
            S_ALUWB: begin
                regwrite_c = 1'b1;
                regdst_c   = 1'b1;
            end
            S_BRANCH: begin
                alusrca_c = 1'b1;
                aluop     = AOP_SUB;
                pcsrc_c   = PC_ALUOUT;
                branch    = ((bus.op == OP_BEQ) &&  bus.zero) ||
                            ((bus.op == OP_BNE) && !bus.zero);
            end
            S_IMMEX: begin
                alusrca_c = 1'b1;
                alusrcb_c = SRCB_IMM;
                aluop     = AOP_IMM;
                state_d   = S_IMMWB;
            end
            S_IMMWB: regwrite_c = 1'b1;
            S_JUMP: begin
                pcsrc_c = PC_JUMP;
                pcwrite = 1'b1;
            end
`ifdef MC_JAL_EN
            S_JAL: begin
                regwrite_c = 1'b1;
                jal_c      = 1'b1;
                pcsrc_c    = PC_JUMP;
                pcwrite    = 1'b1;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Write strobes are gated by reset so an asynchronous abort suppresses them at once.
    assign bus.pcen       = ~reset & (pcwrite | branch);
    assign bus.irwrite    = ~reset & irwrite_c;
    assign bus.memwrite   = ~reset & memwrite_c;
    assign bus.regwrite   = ~reset & regwrite_c;
    assign bus.illegal    = ~reset & illegal_c;
    assign bus.iord       = iord_c;
    assign bus.regdst     = regdst_c;
    assign bus.memtoreg   = memtoreg_c;
    assign bus.alusrca    = alusrca_c;
    assign bus.alusrcb    = alusrcb_c;
    assign bus.pcsrc      = pcsrc_c;
    assign bus.alucontrol = alucontrol;
    assign bus.jal        = jal_c;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed table-driven bench for mc_controller, with hand sequences for reset abort and jal.
module tb_mc_controller;

    logic clk = 1'b0;
    logic reset;

    mc_controller_if bus();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic [21:0] exp;
    } vec_t;

    vec_t vecs[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // {state, pcen iord memwrite irwrite regdst memtoreg regwrite alusrca, alusrcb, pcsrc, alucontrol, illegal, jal}
    function automatic logic [21:0] e(input logic [3:0] st, input logic [7:0] fl,
                                      input logic [1:0] sb, input logic [1:0] ps,
                                      input logic [3:0] alu, input logic ill, input logic j);
        return {st, fl, sb, ps, alu, ill, j};
    endfunction

    function automatic logic [21:0] actual();
        return {bus.state, bus.pcen, bus.iord, bus.memwrite, bus.irwrite, bus.regdst,
                bus.memtoreg, bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc,
                bus.alucontrol, bus.illegal, bus.jal};
    endfunction

    task automatic add(input string name, input logic r, input logic [5:0] op,
                       input logic [5:0] fn, input logic z, input logic [21:0] exp);
        vec_t v;
        v.name = name; v.rst = r; v.op = op; v.funct = fn; v.zero = z; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [21:0] got, input logic [21:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %06h want %06h", name, got, want);
        end
    endtask

    logic [21:0] X_RST, X_FETCH, X_DEC, X_DEC_ILL, X_MEMADR, X_MEMRD, X_MEMWB, X_MEMWR;
    logic [21:0] X_ALUWB, X_IMMWB, X_JUMP, X_JAL;

    initial begin
        reset = 1'b1;
        bus.op = 6'b0; bus.funct = 6'b0; bus.zero = 1'b0;

        X_RST     = e(4'd0,  8'b0000_0000, 2'b01, 2'b00, 4'b0010, 1'b0, 1'b0);
        X_FETCH   = e(4'd0,  8'b1001_0000, 2'b01, 2'b00, 4'b0010, 1'b0, 1'b0);
        X_DEC     = e(4'd1,  8'b0000_0000, 2'b11, 2'b00, 4'b0010, 1'b0, 1'b0);
        X_DEC_ILL = e(4'd1,  8'b0000_0000, 2'b11, 2'b00, 4'b0010, 1'b1, 1'b0);
        X_MEMADR  = e(4'd2,  8'b0000_0001, 2'b10, 2'b00, 4'b0010, 1'b0, 1'b0);
        X_MEMRD   = e(4'd3,  8'b0100_0000, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0);
        X_MEMWB   = e(4'd4,  8'b0000_0110, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0);
        X_MEMWR   = e(4'd5,  8'b0110_0000, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0);
        X_ALUWB   = e(4'd7,  8'b0000_1010, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0);
        X_IMMWB   = e(4'd10, 8'b0000_0010, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0);
        X_JUMP    = e(4'd11, 8'b1000_0000, 2'b00, 2'b10, 4'b0000, 1'b0, 1'b0);
        X_JAL     = e(4'd12, 8'b1000_0010, 2'b00, 2'b10, 4'b0000, 1'b0, 1'b1);

        add("rst0",       1, 6'b100011, 6'b0, 0, X_RST);
        add("rst1",       1, 6'b100011, 6'b0, 0, X_RST);
        add("lw_fetch",   0, 6'b100011, 6'b0, 0, X_FETCH);
        add("lw_decode",  0, 6'b100011, 6'b0, 0, X_DEC);
        add("lw_memadr",  0, 6'b100011, 6'b0, 0, X_MEMADR);
        add("lw_memrd",   0, 6'b100011, 6'b0, 0, X_MEMRD);
        add("lw_memwb",   0, 6'b100011, 6'b0, 0, X_MEMWB);
        add("sw_fetch",   0, 6'b101011, 6'b0, 0, X_FETCH);
        add("sw_decode",  0, 6'b101011, 6'b0, 0, X_DEC);
        add("sw_memadr",  0, 6'b101011, 6'b0, 0, X_MEMADR);
        add("sw_memwr",   0, 6'b101011, 6'b0, 0, X_MEMWR);
        add("slt_fetch",  0, 6'b000000, 6'b101010, 0, X_FETCH);
        add("slt_decode", 0, 6'b000000, 6'b101010, 0, X_DEC);
        add("slt_exec",   0, 6'b000000, 6'b101010, 0, e(4'd6, 8'b0000_0001, 2'b00, 2'b00, 4'b1011, 1'b0, 1'b0));
        add("slt_aluwb",  0, 6'b000000, 6'b101010, 0, X_ALUWB);
        add("badfn_fetch",  0, 6'b000000, 6'b111111, 0, X_FETCH);
        add("badfn_decode", 0, 6'b000000, 6'b111111, 0, X_DEC);
        add("badfn_exec",   0, 6'b000000, 6'b111111, 0, e(4'd6, 8'b0000_0001, 2'b00, 2'b00, 4'b0000, 1'b1, 1'b0));
        add("badfn_after",  0, 6'b000100, 6'b0, 1, X_FETCH);
        add("beq_decode",   0, 6'b000100, 6'b0, 1, X_DEC);
        add("beq_taken",    0, 6'b000100, 6'b0, 1, e(4'd8, 8'b1000_0001, 2'b00, 2'b01, 4'b1010, 1'b0, 1'b0));
        add("beq2_fetch",   0, 6'b000100, 6'b0, 0, X_FETCH);
        add("beq2_decode",  0, 6'b000100, 6'b0, 0, X_DEC);
        add("beq_nottaken", 0, 6'b000100, 6'b0, 0, e(4'd8, 8'b0000_0001, 2'b00, 2'b01, 4'b1010, 1'b0, 1'b0));
        add("bne_fetch",    0, 6'b000101, 6'b0, 0, X_FETCH);
        add("bne_decode",   0, 6'b000101, 6'b0, 0, X_DEC);
        add("bne_taken",    0, 6'b000101, 6'b0, 0, e(4'd8, 8'b1000_0001, 2'b00, 2'b01, 4'b1010, 1'b0, 1'b0));
        add("badop_fetch",  0, 6'b111111, 6'b0, 0, X_FETCH);
        add("badop_decode", 0, 6'b111111, 6'b0, 0, X_DEC_ILL);
        add("badop_after",  0, 6'b001101, 6'b0, 0, X_FETCH);
        add("ori_decode",   0, 6'b001101, 6'b0, 0, X_DEC);
        add("ori_immex",    0, 6'b001101, 6'b0, 0, e(4'd9, 8'b0000_0001, 2'b10, 2'b00, 4'b0001, 1'b0, 1'b0));
        add("ori_immwb",    0, 6'b001101, 6'b0, 0, X_IMMWB);
        add("j_fetch",      0, 6'b000010, 6'b0, 0, X_FETCH);
        add("j_decode",     0, 6'b000010, 6'b0, 0, X_DEC);
        add("j_jump",       0, 6'b000010, 6'b0, 0, X_JUMP);
        add("xori_fetch",   0, 6'b001110, 6'b0, 0, X_FETCH);
        add("xori_decode",  0, 6'b001110, 6'b0, 0, X_DEC);
        add("xori_immex",   0, 6'b001110, 6'b0, 0, e(4'd9, 8'b0000_0001, 2'b10, 2'b00, 4'b0111, 1'b0, 1'b0));
        add("xori_immwb",   0, 6'b001110, 6'b0, 0, X_IMMWB);
        add("sub_fetch",    0, 6'b000000, 6'b100010, 0, X_FETCH);
        add("sub_decode",   0, 6'b000000, 6'b100010, 0, X_DEC);
        add("sub_exec",     0, 6'b000000, 6'b100010, 0, e(4'd6, 8'b0000_0001, 2'b00, 2'b00, 4'b1010, 1'b0, 1'b0));
        add("sub_aluwb",    0, 6'b000000, 6'b100010, 0, X_ALUWB);
        add("swr_fetch",    0, 6'b101011, 6'b0, 0, X_FETCH);
        add("swr_decode",   0, 6'b101011, 6'b0, 0, X_DEC);
        add("swr_memadr",   0, 6'b101011, 6'b0, 0, X_MEMADR);

        #1;
        foreach (vecs[i]) begin
            reset     = vecs[i].rst;
            bus.op    = vecs[i].op;
            bus.funct = vecs[i].funct;
            bus.zero  = vecs[i].zero;
            @(negedge clk);
            check(vecs[i].name, actual(), vecs[i].exp);
            @(posedge clk);
            #1;
        end

        // Reset asserted mid-cycle in MEMWR aborts the store immediately.
        @(negedge clk);
        check("swr_memwr", actual(), X_MEMWR);
        #1 reset = 1'b1;
        #1 check("swr_abort", actual(), X_RST);
        @(posedge clk);
        #1 check("swr_hold", actual(), X_RST);

        reset  = 1'b0;
        bus.op = 6'b000011;
        @(negedge clk);
        check("jal_fetch", actual(), X_FETCH);
        @(posedge clk);
        #1;
        @(negedge clk);
`ifdef MC_JAL_EN
        check("jal_decode", actual(), X_DEC);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("jal_state", actual(), X_JAL);
`else
        check("jal_decode", actual(), X_DEC_ILL);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("jal_state", actual(), X_FETCH);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The module SHALL have the following ports, one per line: name, direction, width, meaning; clock and reset come first.
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  6  instr[31:26], sampled from the instruction register.
- funct  in  6  instr[5:0].
- zero  in  1  ALU zero flag.
- pcen  out  1  PC register enable.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- memwrite  out  1  data memory write strobe.
- irwrite  out  1  instruction register load.
- regdst  out  1  register write address: 0=rt, 1=rd.
- memtoreg  out  1  register write data: 0=ALUOut, 1=data register.
- regwrite  out  1  register file write enable.
- alusrca  out  1  ALU A source: 0=PC, 1=A register.
- alusrcb  out  2  ALU B source: 00=B register, 01=4, 10=signimm, 11=signimm<<2.
- pcsrc  out  2  next PC source: 00=ALU result, 01=ALUOut, 10=jump target, 11=reserved.
- alucontrol  out  4  alu32 F code.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- state  out  4  current state, for debug.

Function
REQ-002 The controller SHALL be a Moore FSM. Its states and encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, IMMEX=9, IMMWB=10, JUMP=11, JAL=12.
REQ-003 FETCH SHALL assert iord=0, irwrite=1, alusrca=0, alusrcb=01, alucontrol=0010, pcsrc=00 and pcwrite, then go to DECODE.
REQ-004 DECODE SHALL assert alusrca=0, alusrcb=11 and alucontrol=0010 to compute the branch target.
REQ-005 DECODE SHALL branch on op as follows: 100011/101011 -> MEMADR; 000000 -> EXEC; 000100/000101 -> BRANCH; 001000/001100/001101/001110/001010 -> IMMEX; 000010 -> JUMP; 000011 -> JAL.
REQ-006 Any other op in DECODE SHALL pulse illegal for one cycle and return to FETCH with no register or memory write.
REQ-007 MEMADR SHALL use alusrca=1, alusrcb=10 and add; it SHALL go to MEMRD for lw and MEMWR for sw.
REQ-008 MEMRD SHALL assert iord=1 and go to MEMWB.
REQ-009 MEMWB SHALL assert regwrite=1, regdst=0 and memtoreg=1, then go to FETCH.
REQ-010 MEMWR SHALL assert iord=1 and memwrite=1, then go to FETCH.
REQ-011 EXEC SHALL use alusrca=1 and alusrcb=00, with alucontrol from the funct decode: 100000=0010, 100010=1010, 100100=0000, 100101=0001, 101010=1011, 000000=0100, 000010=0101, 000011=0110.
REQ-012 An unlisted funct in EXEC SHALL pulse illegal and go to FETCH without entering ALUWB.
REQ-013 ALUWB SHALL assert regwrite=1, regdst=1 and memtoreg=0.
REQ-014 IMMEX SHALL use alusrca=1 and alusrcb=10, with alucontrol by op: addi=0010, andi=0000, ori=0001, xori=0111, slti=1011.
REQ-015 IMMWB SHALL assert regwrite=1, regdst=0 and memtoreg=0.
REQ-016 BRANCH SHALL use alusrca=1, alusrcb=00, alucontrol=1010 and pcsrc=01, with pcen = beq&zero | bne&~zero.
REQ-017 JUMP SHALL assert pcsrc=10 and pcwrite.
REQ-018 pcen SHALL equal pcwrite | branch-taken and is the only output that combines state with an input.
REQ-019 Every output not named for a state SHALL be 0 in that state.
REQ-020 Cycle counts SHALL be: lw 5, sw 4, R-type 4, I-type ALU 4, branch 3, j 3, jal 3.

Reset
REQ-021 While reset is high, state SHALL be FETCH and pcen, irwrite, memwrite, regwrite and illegal SHALL be forced to 0; all other outputs take their FETCH values.
REQ-022 Reset asserted mid-instruction SHALL abort it with no write on any edge while asserted.
REQ-023 The first rising edge after reset deassertion SHALL perform the FETCH writes.

Configuration
REQ-024 With MC_JAL_EN defined, op 000011 SHALL go to JAL, which asserts regwrite=1, writes PC+4 to r31 (register write address forced to 31 via a jal output bit), pcsrc=10 and pcwrite, then goes to FETCH.
REQ-025 Without MC_JAL_EN, op 000011 SHALL be treated as illegal and state 12 SHALL be unreachable.

Structure
REQ-026 A shared package SHALL hold the state enum, opcode and funct constants, and the 4-bit alucontrol codes (matching alu32).
REQ-027 The funct/op-to-alucontrol decode SHALL be one combinational sub-module named mc_aludec; the FSM and output decode SHALL stay in mc_controller.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Reset, then release -> outputs quiet during reset; first edge: irwrite=1, pcen=1, state 0->1.
- lw (op 100011) -> states 0,1,2,3,4,0; iord=1 in state 3; regwrite=1 and memtoreg=1 in state 4 only.
- beq with zero=1, then zero=0 -> pcen=1/0 in BRANCH; bne with zero=0 -> pcen=1.
- R-type funct 101010 -> alucontrol=1011 in EXEC; funct 111111 -> illegal pulse and no regwrite.
- op 111111 in DECODE -> illegal high for exactly one cycle, next state FETCH.
- Reset asserted in MEMWR -> memwrite drops immediately, state=FETCH; op 000011 -> JAL state with MC_JAL_EN, illegal without it.
